// File: rtl/serial_adder.sv
// Area-lean multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB slice first,
// with the inter-slice carry kept in a flop and results held until the next completion.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q;
  logic [WIDTH-1:0]          a_q, b_q;
  logic                      carry_q;
  logic                      a_msb_q, b_msb_q;
  logic [CW-1:0]             cnt_q;
  logic                      busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0]          sum_q;
  logic [BITS_PER_CYCLE:0]   slice_d;
  logic [WIDTH-1:0]          full_d;

  // One shared full-adder slice: {carry, s} = a_slice + b_slice + carry.
  always_comb begin
    slice_d = {1'b0, a_q[BITS_PER_CYCLE-1:0]}
            + {1'b0, b_q[BITS_PER_CYCLE-1:0]}
            + {{BITS_PER_CYCLE{1'b0}}, carry_q};
  end

  // Partial result register only needs the bits still to be completed; the
  // newest slice is prepended from the MSB side to form the full word.
  generate
    if (N > 1) begin : g_multi
      logic [WIDTH-BITS_PER_CYCLE-1:0] res_q;
      assign full_d = {slice_d[BITS_PER_CYCLE-1:0], res_q};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else if (state_q == RUN) begin
          res_q <= full_d[WIDTH-1:BITS_PER_CYCLE];
        end
      end
    end else begin : g_single
      assign full_d = slice_d[BITS_PER_CYCLE-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> BITS_PER_CYCLE;
          b_q     <= b_q >> BITS_PER_CYCLE;
          carry_q <= slice_d[BITS_PER_CYCLE];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= full_d;
            cout_q  <= slice_d[BITS_PER_CYCLE];
            ovf_q   <= (a_msb_q == b_msb_q) && (full_d[WIDTH-1] != a_msb_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed plus random checks of serial_adder (8-bit x1 and 16-bit x4 instances)
// against a plain-arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_sum [2];
  logic        exp_co  [2];
  logic        exp_ov  [2];
  logic [15:0] prev_sum[2];
  logic        prev_co [2];
  logic        prev_ov [2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: unsigned sum for result/carry, true signed range test for overflow.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       output logic [15:0] s, output logic co, output logic ov);
    longint m, la, lb, be, t, sa, sb, tr;
    m  = longint'(1) << w;
    la = longint'(a);
    lb = longint'(b);
    be = sub ? (m - 1 - lb) : lb;
    t  = la + be + (sub ? 1 : longint'(cin));
    s  = 16'(t % m);
    co = (t >= m);
    sa = (la >= m / 2) ? la - m : la;
    sb = (lb >= m / 2) ? lb - m : lb;
    tr = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ov = (tr < -(m / 2)) || (tr >= m / 2);
  endtask

  task automatic get(input bit w, output logic bz, output logic dn, output logic [15:0] s,
                     output logic co, output logic ov);
    if (w) begin bz = busy16; dn = done16; s = sum16;        co = cout16; ov = ovf16; end
    else   begin bz = busy8;  dn = done8;  s = {8'h00, sum8}; co = cout8;  ov = ovf8;  end
  endtask

  task automatic launch(input bit w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
    model(w ? 16 : 8, a, b, cin, sub, exp_sum[w], exp_co[w], exp_ov[w]);
    if (w) begin start16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub; end
    else   begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; end
  endtask

  // Follows one operation from the accepting edge to the done pulse; glitch>0 re-pulses
  // start with zero operands during that RUN cycle (8-bit instance only).
  task automatic finish(input bit w, input int glitch);
    int n;
    logic bz, dn, co, ov;
    logic [15:0] s;
    n = w ? 4 : 8;
    @(negedge clk);
    if (w) start16 = 1'b0; else start8 = 1'b0;
    get(w, bz, dn, s, co, ov);
    chk("busy_after_start", {15'b0, bz}, 16'd1);
    chk("done_after_start", {15'b0, dn}, 16'd0);
    chk("sum_hold_start", s, prev_sum[w]);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      if (!w) begin
        start8 = (k == glitch);
        if (k == glitch) begin a8 = 8'h00; b8 = 8'h00; end
      end
      get(w, bz, dn, s, co, ov);
      chk("busy_run", {15'b0, bz}, 16'd1);
      chk("done_run", {15'b0, dn}, 16'd0);
      chk("sum_hold_run", s, prev_sum[w]);
      chk("cout_hold_run", {15'b0, co}, {15'b0, prev_co[w]});
      chk("ovf_hold_run", {15'b0, ov}, {15'b0, prev_ov[w]});
    end
    @(negedge clk);
    if (w) start16 = 1'b0; else start8 = 1'b0;
    get(w, bz, dn, s, co, ov);
    chk("done_pulse", {15'b0, dn}, 16'd1);
    chk("busy_end", {15'b0, bz}, 16'd0);
    chk("sum", s, exp_sum[w]);
    chk("cout", {15'b0, co}, {15'b0, exp_co[w]});
    chk("overflow", {15'b0, ov}, {15'b0, exp_ov[w]});
    $display("txn w=%0d sum=%h cout=%b ovf=%b (exp %h %b %b)", n * (w ? 4 : 1), s, co, ov,
             exp_sum[w], exp_co[w], exp_ov[w]);
    prev_sum[w] = exp_sum[w];
    prev_co[w]  = exp_co[w];
    prev_ov[w]  = exp_ov[w];
  endtask

  task automatic idle_chk(input bit w);
    logic bz, dn, co, ov;
    logic [15:0] s;
    @(negedge clk);
    get(w, bz, dn, s, co, ov);
    chk("done_low_idle", {15'b0, dn}, 16'd0);
    chk("busy_low_idle", {15'b0, bz}, 16'd0);
  endtask

  initial begin
    logic bz, dn, co, ov;
    logic [15:0] s;
    rst_n = 1'b0;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
    for (int i = 0; i < 2; i++) begin
      prev_sum[i] = '0; prev_co[i] = 1'b0; prev_ov[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      get(i[0], bz, dn, s, co, ov);
      chk("rst_busy", {15'b0, bz}, 16'd0);
      chk("rst_done", {15'b0, dn}, 16'd0);
      chk("rst_sum", s, 16'd0);
      chk("rst_cout", {15'b0, co}, 16'd0);
      chk("rst_ovf", {15'b0, ov}, 16'd0);
    end
    rst_n = 1'b1;

    // Directed 8-bit cases, including an ignored start in RUN and a back-to-back chain.
    @(negedge clk); launch(0, 16'h5A, 16'h33, 1'b0, 1'b0); finish(0, 3);
    chk("dir_5a_33", {8'h00, sum8}, 16'h8D);
    idle_chk(0);
    launch(0, 16'hFF, 16'h01, 1'b1, 1'b0); finish(0, 0);
    launch(0, 16'h10, 16'h20, 1'b1, 1'b1); finish(0, 0);
    chk("dir_sub_10_20", {8'h00, sum8}, 16'hF0);
    launch(0, 16'h80, 16'h01, 1'b0, 1'b1); finish(0, 0);
    chk("dir_sub_80_01", {8'h00, sum8}, 16'h7F);
    idle_chk(0);

    // Reset during RUN cycle 4 aborts the operation with no done pulse.
    launch(0, 16'hC3, 16'h7E, 1'b0, 1'b0);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    get(0, bz, dn, s, co, ov);
    chk("midrst_busy", {15'b0, bz}, 16'd0);
    chk("midrst_sum", s, 16'd0);
    chk("midrst_cout", {15'b0, co}, 16'd0);
    chk("midrst_ovf", {15'b0, ov}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prev_sum[i] = '0; prev_co[i] = 1'b0; prev_ov[i] = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      get(0, bz, dn, s, co, ov);
      chk("midrst_no_done", {15'b0, dn}, 16'd0);
    end
    launch(0, 16'h01, 16'h01, 1'b0, 1'b0); finish(0, 0);
    chk("after_rst_1p1", {8'h00, sum8}, 16'h02);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 0) idle_chk(0);
      launch(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish(0, 0);
    end
    idle_chk(0);

    // 16-bit, 4 bits per cycle.
    @(negedge clk); launch(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0); finish(1, 0);
    chk("w16_ffff_1", sum16, 16'h0000);
    chk("w16_ffff_1_cout", {15'b0, cout16}, 16'd1);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) idle_chk(1);
      launch(1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish(1, 0);
    end
    idle_chk(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
